// File: rtl/pipelined_barrel_shifter_pkg.sv
// pipelined_barrel_shifter_pkg: op encodings and stage-distance helper for the barrel shifter
package pipelined_barrel_shifter_pkg;
   typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;
   function automatic int level_dist(int shw, int k);
      return 1 << (shw - 1 - k);
   endfunction
endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// shift_stage: one conditional shift-by-DIST level plus its elastic pipeline register
module shift_stage
   import pipelined_barrel_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST = 1,
   parameter int TAG_W = 4,
   localparam int SHW = $clog2(WIDTH),
   localparam int B = $clog2(DIST)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             next_adv,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] prev_data,
   input  logic [SHW-1:0]   prev_shamt,
   input  logic [1:0]       prev_op,
   input  logic             prev_sign,
   input  logic [TAG_W-1:0] prev_tag,
   output logic             adv,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [SHW-1:0]   shamt,
   output logic [1:0]       op,
   output logic             sign,
   output logic [TAG_W-1:0] tag
);
   logic [WIDTH-1:0] nxt;
   assign adv = !valid || next_adv;
   always_comb begin
      nxt = !prev_shamt[B]     ? prev_data :
            prev_op == OP_SLL  ? prev_data << DIST :
            prev_op == OP_SRL  ? prev_data >> DIST :
            prev_op == OP_SRA  ? {{DIST{prev_sign}}, prev_data[WIDTH-1:DIST]} :
                                 {prev_data[DIST-1:0], prev_data[WIDTH-1:DIST]};
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         shamt <= '0;
         op    <= '0;
         sign  <= 1'b0;
         tag   <= '0;
      end else begin
         if (flush) valid <= 1'b0;
         else if (adv) valid <= prev_valid;
         if (adv) begin
            data  <= nxt;
            shamt <= prev_shamt;
            op    <= prev_op;
            sign  <= prev_sign;
            tag   <= prev_tag;
         end
      end
   end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SLL/SRL/SRA/ROR, one shift level per stage, elastic valid/ready
module pipelined_barrel_shifter
   import pipelined_barrel_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);
   logic [WIDTH-1:0] d [SHW+1];
   logic [SHW-1:0]   s [SHW+1];
   logic [1:0]       o [SHW+1];
   logic [TAG_W-1:0] t [SHW+1];
   logic [SHW:0]     v, sg, adv;
   logic             unused;
   assign d[0]  = in_data;
   assign s[0]  = in_shamt;
   assign o[0]  = in_op;
   assign t[0]  = in_tag;
   assign v[0]  = in_valid;
   assign sg[0] = in_data[WIDTH-1];
   assign adv[SHW] = out_ready;
   genvar k;
   generate
      for (k = 0; k < SHW; k++) begin : g_stage
         shift_stage #(.WIDTH(WIDTH), .DIST(level_dist(SHW, k)), .TAG_W(TAG_W)) u_stage (
            .clk(clk), .reset(reset), .flush(flush), .next_adv(adv[k+1]),
            .prev_valid(v[k]), .prev_data(d[k]), .prev_shamt(s[k]), .prev_op(o[k]),
            .prev_sign(sg[k]), .prev_tag(t[k]),
            .adv(adv[k]), .valid(v[k+1]), .data(d[k+1]), .shamt(s[k+1]), .op(o[k+1]),
            .sign(sg[k+1]), .tag(t[k+1])
         );
      end
   endgenerate
   assign in_ready  = adv[0] && !flush;
   assign out_valid = v[SHW];
   assign out_data  = d[SHW];
   assign out_tag   = t[SHW];
   assign unused    = ^{s[SHW], o[SHW], sg[SHW]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed vectors with a queue scoreboard and decoupled monitor
module tb_pipelined_barrel_shifter;
   import pipelined_barrel_shifter_pkg::*;
   localparam int W = 32, SW = 5, TW = 4;
   logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid;
   logic [W-1:0] in_data = '0, out_data;
   logic [SW-1:0] in_shamt = '0;
   logic [1:0] in_op = '0;
   logic [TW-1:0] in_tag = '0, out_tag;
   typedef struct {logic [W-1:0] data; logic [TW-1:0] tag; int due;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0, cyc = 0;
   bit lat_chk = 1;

   pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] model(logic [1:0] op, logic [W-1:0] x, logic [SW-1:0] sh);
      case (op)
         OP_SLL:  return x << sh;
         OP_SRL:  return x >> sh;
         OP_SRA:  return W'($signed(x) >>> sh);
         default: return (x >> sh) | (x << (6'd32 - {1'b0, sh}));
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         if (q.size() == 0) check("spurious out_valid", {31'b0, out_valid}, 0);
         else begin
            e = q.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
            if (e.due >= 0) check("latency", cyc, e.due);
         end
      end
   end

   task automatic send(logic [1:0] op, logic [W-1:0] x, logic [SW-1:0] sh, logic [TW-1:0] tag, logic [W-1:0] exp);
      int n = 0;
      bit done = 0;
      @(posedge clk); #1;
      in_valid = 1; in_op = op; in_data = x; in_shamt = sh; in_tag = tag;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back('{exp, tag, lat_chk ? cyc + SW : -1});
            done = 1;
         end else if (++n > 60) begin
            check("accept timeout", {31'b0, in_ready}, 1);
            done = 1;
         end
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", q.size(), 0);
   endtask

   initial begin
      bit seen;
      #12;
      check("reset out_valid", {31'b0, out_valid}, 0);
      check("reset out_data", out_data, 0);
      check("reset out_tag", {28'b0, out_tag}, 0);
      check("reset in_ready", {31'b0, in_ready}, 1);
      @(negedge clk) reset = 0;
      // single op latency and sign fill
      send(OP_SRA, 32'h80000000, 4, 3, 32'hF8000000);
      idle(); drain();
      // directed vectors including shamt boundaries
      send(OP_ROR, 32'h00000001, 1, 1, 32'h80000000);
      send(OP_SLL, 32'h0000FFFF, 16, 2, 32'hFFFF0000);
      send(OP_SRL, 32'hF0000000, 31, 3, 32'h00000001);
      send(OP_SRA, 32'h80000000, 31, 4, 32'hFFFFFFFF);
      send(OP_SRA, 32'h7FFFFFFF, 4, 5, 32'h07FFFFFF);
      send(OP_ROR, 32'h12345678, 31, 6, 32'h2468ACF0);
      send(OP_SLL, 32'hA5A5A5A5, 0, 7, 32'hA5A5A5A5);
      send(OP_SRL, 32'hA5A5A5A5, 0, 8, 32'hA5A5A5A5);
      send(OP_SRA, 32'h80000001, 0, 9, 32'h80000001);
      send(OP_ROR, 32'hDEADBEEF, 0, 10, 32'hDEADBEEF);
      idle(); drain();
      // back-to-back stream against the reference model
      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] x;
         logic [SW-1:0] sh;
         x = 32'h8BADF00D + i * 32'h11111111;
         sh = SW'(i * 7 + 1);
         send(2'(i), x, sh, TW'(i), model(2'(i), x, sh));
      end
      idle(); drain();
      // back-pressure: fill the pipe then hold
      lat_chk = 0;
      @(posedge clk); #1 out_ready = 0;
      send(OP_SLL, 32'h00000003, 1, 1, 32'h00000006);
      send(OP_SRL, 32'h00000080, 7, 2, 32'h00000001);
      send(OP_SRA, 32'hFFFF0000, 8, 3, 32'hFFFFFF00);
      send(OP_ROR, 32'h0000000F, 4, 4, 32'hF0000000);
      send(OP_SLL, 32'h12345678, 4, 5, 32'h23456780);
      fork
         send(OP_SRL, 32'h12345678, 4, 6, 32'h01234567);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               check("hold out_data", out_data, 32'h00000006);
               check("hold in_ready", {31'b0, in_ready}, 0);
            end
            @(posedge clk); #1 out_ready = 1;
         end
      join
      idle(); drain();
      // flush with ops in flight and a simultaneous input
      lat_chk = 1;
      send(OP_SLL, 32'h1, 1, 1, 32'h2);
      send(OP_SLL, 32'h1, 2, 2, 32'h4);
      send(OP_SLL, 32'h1, 3, 3, 32'h8);
      @(posedge clk); #1;
      flush = 1; in_valid = 1; in_data = 32'hFFFF; in_tag = 4'hF;
      @(negedge clk);
      check("in_ready during flush", {31'b0, in_ready}, 0);
      q.delete();
      @(posedge clk); #1;
      flush = 0; in_valid = 0;
      seen = 0;
      repeat (8) @(negedge clk) if (out_valid) seen = 1;
      check("no output after flush", {31'b0, seen}, 0);
      send(OP_SLL, 32'h1, 5, 12, 32'h20);
      idle(); drain();
      // async reset with ops in flight
      lat_chk = 0;
      @(posedge clk); #1 out_ready = 0;
      for (int i = 0; i < 4; i++) send(OP_SLL, 32'hFF, 1, TW'(i), 32'h1FE);
      idle();
      repeat (4) @(negedge clk);
      check("pre-reset out_valid", {31'b0, out_valid}, 1);
      @(posedge clk); #3 reset = 1;
      #1;
      check("mid reset out_valid", {31'b0, out_valid}, 0);
      check("mid reset in_ready", {31'b0, in_ready}, 1);
      check("mid reset out_data", out_data, 0);
      q.delete();
      out_ready = 1;
      @(posedge clk); #3 reset = 0;
      lat_chk = 1;
      send(OP_SRL, 32'h00000100, 8, 13, 32'h00000001);
      idle(); drain();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: reached %0d checks", checks);
      $fatal(1, "timeout");
   end
endmodule
